// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage in front of the 1024x32 data memory.
// Converts byte-addressed core requests into word strobes, performs
// read-modify-write for sub-word stores, and extracts/extends load data.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses fault
// instead of aligning down).
module load_store_unit #(
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t state, next_state;

  logic              store_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [MEM_AW+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;

  logic              is_byte, is_half, is_word;
  logic              needs_read;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  // Address bits above the memory index wrap away and are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_W-1:MEM_AW+2];

  // Size 2'b11 behaves as a word access.
  assign is_byte    = (size_q == 2'b00);
  assign is_half    = (size_q == 2'b01);
  assign is_word    = size_q[1];
  assign needs_read = !(store_q && is_word);

`ifdef LSU_MISALIGN_TRAP_EN
  logic fault_q;
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`endif

  // State register with asynchronous return to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Sequencing: accept, access, optional merge write, then respond.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
`ifdef LSU_MISALIGN_TRAP_EN
          next_state = misaligned ? RESP : ACCESS;
`else
          next_state = ACCESS;
`endif
        end
      end
      ACCESS:  next_state = (store_q && !is_word) ? MERGE : RESP;
      MERGE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latch the request on accept and capture the memory word during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      if (state == IDLE && req_valid) begin
        store_q    <= req_store;
        size_q     <= req_size;
        unsigned_q <= req_unsigned;
        addr_q     <= req_addr[MEM_AW+1:0];
        wdata_q    <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
        fault_q    <= misaligned;
`endif
      end
      if (state == ACCESS && needs_read) word_q <= mem_data_out;
    end
  end

  // Pick the addressed byte/halfword and extend it to 32 bits.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    sel_byte = word_q[7:0];
      2'd1:    sel_byte = word_q[15:8];
      2'd2:    sel_byte = word_q[23:16];
      default: sel_byte = word_q[31:24];
    endcase
    sel_half = addr_q[1] ? word_q[31:16] : word_q[15:0];
    if (is_byte)      load_val = {{24{~unsigned_q & sel_byte[7]}}, sel_byte};
    else if (is_half) load_val = {{16{~unsigned_q & sel_half[15]}}, sel_half};
    else              load_val = word_q;
  end

  // Splice store data into the captured word for read-modify-write.
  always_comb begin
    merged = word_q;
    if (is_byte) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (is_half) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
    end
  end

  // Port decode from the current state and latched request.
  always_comb begin
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_fault  = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        mem_address = addr_q[MEM_AW+1:2];
        if (needs_read) begin
          mem_read = 1'b1;
        end else begin
          mem_write   = 1'b1;
          mem_data_in = wdata_q;
        end
      end
      MERGE: begin
        mem_address = addr_q[MEM_AW+1:2];
        mem_write   = 1'b1;
        mem_data_in = merged;
      end
      RESP: begin
        resp_valid = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        resp_fault = fault_q;
        resp_rdata = (store_q || fault_q) ? 32'd0 : load_val;
`else
        resp_rdata = store_q ? 32'd0 : load_val;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit with a word
// memory model, a directed vector table, a reset-during-merge sequence and
// randomized traffic checked against a transaction-level reference model.
// Honors LSU_MISALIGN_TRAP_EN for expected values.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [9:0]  mem_address;
  logic [31:0] mem_data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_data_out;

  int asserts  = 0;
  int failures = 0;

  // Data memory seen by the DUT, and the reference model's memory image.
  bit [31:0] tbmem  [1024];
  bit [31:0] refmem [1024];

  typedef struct {
    bit        st;
    bit [1:0]  sz;
    bit        un;
    bit [31:0] ad;
    bit [31:0] wd;
    bit [31:0] exp_rdata;
    int        exp_lat;
    bit        exp_fault;
    string     name;
  } vec_t;

  vec_t vecs[$];

  load_store_unit #(.ADDR_W(32), .MEM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_read(mem_read), .mem_write(mem_write), .mem_data_out(mem_data_out)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-write, combinational-read memory.
  always @(posedge clk) begin
    if (mem_write) tbmem[mem_address] <= mem_data_in;
  end
  assign mem_data_out = tbmem[mem_address];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic void addVec(bit st, bit [1:0] sz, bit un, bit [31:0] ad,
                                 bit [31:0] wd, bit [31:0] er, int el, bit ef,
                                 string name);
    vec_t v;
    v.st = st; v.sz = sz; v.un = un; v.ad = ad; v.wd = wd;
    v.exp_rdata = er; v.exp_lat = el; v.exp_fault = ef; v.name = name;
    vecs.push_back(v);
  endfunction

  // One complete transaction: reference model, drive, observe, compare.
  task automatic applyStimulus(input bit st, input bit [1:0] sz, input bit un,
                               input bit [31:0] ad, input bit [31:0] wd,
                               input bit use_tbl, input bit [31:0] t_rdata,
                               input int t_lat, input bit t_fault,
                               input bit junk, input string name);
    int        nbytes, idx, sh, lat, reads, writes, rd_cyc, wr_cyc, wait_cnt;
    int        exp_lat, exp_reads, exp_writes, exp_wr_cyc;
    bit        misal, fault, both, seen;
    bit [31:0] ea, mask, old, neww, field, exp_rdata;
    logic [31:0] rd_addr, wr_addr, wr_data, got_rdata;
    logic      got_fault;

    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    misal  = (ad % nbytes) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault  = misal;
`else
    fault  = 1'b0;
`endif
    ea   = ad - (ad % nbytes);
    idx  = int'((ea >> 2) % 1024);
    sh   = int'(ea % 4) * 8;
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    old  = refmem[idx];
    neww = old;
    exp_rdata = 32'd0;
    if (fault) begin
      exp_lat = 1; exp_reads = 0; exp_writes = 0; exp_wr_cyc = 0;
    end else if (st) begin
      neww = (old & ~(mask << sh)) | ((wd & mask) << sh);
      exp_lat    = (nbytes == 4) ? 2 : 3;
      exp_reads  = (nbytes == 4) ? 0 : 1;
      exp_writes = 1;
      exp_wr_cyc = (nbytes == 4) ? 1 : 2;
    end else begin
      field = (old >> sh) & mask;
      if (!un && nbytes < 4 && field[8 * nbytes - 1]) field = field | ~mask;
      exp_rdata = field;
      exp_lat = 2; exp_reads = 1; exp_writes = 0; exp_wr_cyc = 0;
    end
    if (use_tbl) begin
      exp_rdata = t_rdata;
      exp_lat   = t_lat;
      fault     = t_fault;
    end

    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd;
    wait_cnt = 0;
    while (!req_ready && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!req_ready) begin
      checkOutput({name, " ready_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);

    lat = 0; reads = 0; writes = 0; rd_cyc = 0; wr_cyc = 0;
    both = 1'b0; seen = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0; got_rdata = '0; got_fault = 1'b0;
    while (!seen && lat < 8) begin
      lat++;
      if (!junk) begin
        req_valid = 1'b0;
      end else begin
        req_store = 1'($urandom); req_size = 2'($urandom);
        req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
      if (mem_read)  begin reads++;  rd_addr = 32'(mem_address); rd_cyc = lat; end
      if (mem_write) begin writes++; wr_addr = 32'(mem_address); wr_data = mem_data_in; wr_cyc = lat; end
      if (mem_read && mem_write) both = 1'b1;
      if (resp_valid) begin
        seen = 1'b1; got_rdata = resp_rdata; got_fault = resp_fault;
      end else begin
        @(negedge clk);
      end
    end
    req_valid = 1'b0;

    checkOutput({name, " resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({name, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, " rdata"}, got_rdata, exp_rdata);
      checkOutput({name, " fault"}, 32'(got_fault), 32'(fault));
    end
    checkOutput({name, " read_count"}, 32'(reads), 32'(exp_reads));
    checkOutput({name, " write_count"}, 32'(writes), 32'(exp_writes));
    checkOutput({name, " rd_wr_overlap"}, 32'(both), 32'd0);
    if (exp_reads > 0 && reads > 0) begin
      checkOutput({name, " read_addr"}, rd_addr, 32'(idx));
      checkOutput({name, " read_cycle"}, 32'(rd_cyc), 32'd1);
    end
    if (exp_writes > 0 && writes > 0) begin
      checkOutput({name, " write_addr"}, wr_addr, 32'(idx));
      checkOutput({name, " write_data"}, wr_data, neww);
      checkOutput({name, " write_cycle"}, 32'(wr_cyc), 32'(exp_wr_cyc));
    end
    if (st && !fault) refmem[idx] = neww;
  endtask

  initial begin
    int        seen_resp;
    int        mism;
    bit [31:0] r;
    bit [31:0] rnd_addr;

    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Directed vectors; memory starts all-zero.
    addVec(1, 2'b10, 0, 32'h04, 32'h0000_0003, 32'h0,          2, 0, "st_w_init");
    addVec(0, 2'b00, 1, 32'h04, 32'h0,         32'h0000_0003,  2, 0, "ld_bu_4");
    addVec(1, 2'b00, 0, 32'h05, 32'h0000_00AB, 32'h0,          3, 0, "st_b_5");
    addVec(0, 2'b10, 0, 32'h04, 32'h0,         32'h0000_AB03,  2, 0, "ld_w_4");
    addVec(0, 2'b00, 0, 32'h05, 32'h0,         32'hFFFF_FFAB,  2, 0, "ld_bs_5");
    addVec(0, 2'b00, 1, 32'h05, 32'h0,         32'h0000_00AB,  2, 0, "ld_bu_5");
    addVec(0, 2'b01, 0, 32'h04, 32'h0,         32'hFFFF_AB03,  2, 0, "ld_hs_4");
    addVec(1, 2'b10, 0, 32'h1C, 32'hDEAD_BEEF, 32'h0,          2, 0, "st_w_1c");
    addVec(0, 2'b11, 0, 32'h1C, 32'h0,         32'hDEAD_BEEF,  2, 0, "ld_sz3_1c");
    addVec(0, 2'b10, 0, 32'h8000_101C, 32'h0,  32'hDEAD_BEEF,  2, 0, "ld_w_wrap");
    addVec(1, 2'b01, 0, 32'h1E, 32'h5555_1234, 32'h0,          3, 0, "st_h_1e");
    addVec(0, 2'b01, 1, 32'h1E, 32'h0,         32'h0000_1234,  2, 0, "ld_hu_1e");
    addVec(0, 2'b01, 0, 32'h1C, 32'h0,         32'hFFFF_BEEF,  2, 0, "ld_hs_1c");
`ifdef LSU_MISALIGN_TRAP_EN
    addVec(0, 2'b10, 0, 32'h06, 32'h0,         32'h0,          1, 1, "ld_w_mis6");
    addVec(0, 2'b01, 0, 32'h1F, 32'h0,         32'h0,          1, 1, "ld_hs_mis1f");
`else
    addVec(0, 2'b10, 0, 32'h06, 32'h0,         32'h0000_AB03,  2, 0, "ld_w_mis6");
    addVec(0, 2'b01, 0, 32'h1F, 32'h0,         32'h0000_1234,  2, 0, "ld_hs_mis1f");
`endif
    addVec(0, 2'b00, 0, 32'h1F, 32'h0,         32'h0000_0012,  2, 0, "ld_bs_1f");

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("reset resp_valid",  32'(resp_valid), 32'd0);
    checkOutput("reset resp_rdata",  resp_rdata, 32'd0);
    checkOutput("reset resp_fault",  32'(resp_fault), 32'd0);
    checkOutput("reset mem_read",    32'(mem_read), 32'd0);
    checkOutput("reset mem_write",   32'(mem_write), 32'd0);
    checkOutput("reset mem_address", 32'(mem_address), 32'd0);
    checkOutput("reset mem_data_in", mem_data_in, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i])
      applyStimulus(vecs[i].st, vecs[i].sz, vecs[i].un, vecs[i].ad, vecs[i].wd,
                    1'b1, vecs[i].exp_rdata, vecs[i].exp_lat, vecs[i].exp_fault,
                    1'b0, vecs[i].name);

    // Reset while the merge write of a byte store is pending.
    $display("[TB] reset during MERGE");
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h05; req_wdata = 32'h77;
    checkOutput("mrst ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("mrst access_read", 32'(mem_read), 32'd1);
    @(negedge clk);
    checkOutput("mrst merge_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mrst mem_write",   32'(mem_write), 32'd0);
    checkOutput("mrst mem_data_in", mem_data_in, 32'd0);
    checkOutput("mrst mem_address", 32'(mem_address), 32'd0);
    checkOutput("mrst resp_valid",  32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mrst req_ready", 32'(req_ready), 32'd1);
    seen_resp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
    end
    checkOutput("mrst no_resp", 32'(seen_resp), 32'd0);
    checkOutput("mrst mem_word1", tbmem[1], refmem[1]);

    // Randomized traffic over a small window of words with random high bits.
    $display("[TB] random traffic");
    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      rnd_addr = (r & 32'hF000_0000) | 32'($urandom_range(0, 63));
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), rnd_addr, $urandom,
                    1'b0, 32'd0, 0, 1'b0, ($urandom_range(0, 3) == 0),
                    $sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    mism = 0;
    for (int k = 0; k < 16; k++) if (tbmem[k] != refmem[k]) mism++;
    checkOutput("final mem_image", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage sitting directly upstream of the 1024x32 data memory; it turns core load/store requests (32-bit byte address, size, sign) into word-level memory read/write strobes. It performs read-modify-write for byte and halfword stores and extracts/extends sub-word load data. It returns a one-cycle response pulse to the core. The valid/ready handshake lets the pipeline stall while the access is in flight.

Parameters:
ADDR_W, 32, width of core byte address.
MEM_AW, 10, data-memory word-address width; memory word index = req_addr[MEM_AW+1:2].

Ports:
clk  input  1  single clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  core presents a request.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_store  input  1  1 = store, 0 = load.
req_size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
req_addr  input  ADDR_W  byte address.
req_wdata  input  32  store data, right-aligned.
resp_valid  output  1  one-cycle completion pulse.
resp_rdata  output  32  load result; 0 for stores.
resp_fault  output  1  misalignment fault (only with optional feature, else 0).
mem_address  output  MEM_AW  word address to data memory.
mem_data_in  output  32  write data to data memory.
mem_read  output  1  read strobe.
mem_write  output  1  write strobe; memory writes on the posedge ending the cycle.
mem_data_out  input  32  combinational read data from memory, valid in the cycle mem_read=1.

Behaviour:
- Reset (async): state=IDLE; req_ready=1 after release; resp_valid, resp_rdata, resp_fault, mem_read, mem_write, mem_address, mem_data_in all 0; latched request cleared.
- Little-endian: byte k of a word = bits [8k+7:8k].
- States: IDLE, ACCESS, MERGE, RESP.
- IDLE: req_ready=1; on req_valid latch store/size/unsigned/addr/wdata, go to ACCESS. No other port activity.
- ACCESS: mem_address = latched word index. Load or sub-word store: mem_read=1 and capture mem_data_out at the posedge. Word store: mem_write=1, mem_data_in=wdata. Next state: MERGE for sub-word store, RESP otherwise.
- MERGE: mem_write=1; mem_data_in = captured word with the addressed byte/halfword replaced by wdata[7:0]/[15:0]; next RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_rdata = extracted field, zero- or sign-extended for loads, 0 for stores; next IDLE.
- Latency from the accept cycle N: load/word store resp_valid at N+2; sub-word store at N+3. Throughput: one request per 3 (resp) + 1 cycles; req_ready is low from ACCESS through RESP.
- Outputs registered or decoded from state only; mem_read and mem_write are never high in the same cycle.
- Address bits above [MEM_AW+1] ignored (wrap modulo memory size). Misaligned access without the feature: halfword ignores addr[0], word ignores addr[1:0].
- resp_valid has no backpressure; the core must accept it.
- Reset mid-operation: returns to IDLE immediately; a pending MERGE write is not issued; no resp_valid.
- req_valid while req_ready=0: ignored, not latched.

Optional Feature:
LSU_MISALIGN_TRAP_EN: when defined, halfword with addr[0]=1 or word with addr[1:0]!=0 goes IDLE->RESP with no memory strobes; RESP drives resp_fault=1 and resp_rdata=0 (resp_valid at N+1). When undefined, resp_fault is tied 0 and addresses align down as above.

Test Plan:
- Memory word1=0x00000003; load byte unsigned addr 0x4 accepted at N -> mem_read at N+1 with mem_address=1; resp_valid at N+2 with resp_rdata=0x00000003.
- Store byte 0xAB at addr 0x5 (word1=0x00000003) -> read at N+1, mem_write at N+2 with mem_data_in=0x0000AB03, resp_valid at N+3; subsequent word load of 0x4 returns 0x0000AB03.
- Word1=0x0000AB03: load byte signed addr 0x5 -> 0xFFFFFFAB; unsigned -> 0x000000AB; halfword signed addr 0x4 -> 0xFFFFAB03.
- Word store 0xDEADBEEF at addr 0x1C -> single mem_write at N+1, mem_address=7, resp_valid at N+2, resp_rdata=0.
- Word load at addr 0x6: without the macro reads word1; with LSU_MISALIGN_TRAP_EN -> resp_valid at N+1, resp_fault=1, no mem_read.
- Assert rst during MERGE of a byte store -> no mem_write, outputs 0, req_ready=1 after release, no resp_valid.
